// File: rtl/fifo_pkg.sv
// Shared async-FIFO types and constants.
// Used by the read-side drain engine and the write-side generator.
package fifo_pkg;

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_t;

  localparam logic [7:0] CHK_POLY_DEF = 8'hB8;
  localparam logic [7:0] CHK_SEED_DEF = 8'hA5;

endpackage

// File: rtl/fifo_lfsr.sv
// Galois LFSR (right shift), one step per cycle with step high.
// Shared by the write generator and the read checker.
module fifo_lfsr
  import fifo_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = CHK_POLY_DEF,
  parameter logic [WIDTH-1:0] SEED = CHK_SEED_DEF
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] nxt;

  // next state: shift right, fold taps in when lsb falls out
  always_comb begin
    nxt = value >> 1;
    if (value[0]) nxt = nxt ^ POLY;
  end

  // sequence register
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)    value <= SEED;
    else if (step) value <= nxt;
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: pops into a 2-entry skid, streams out.
// Optional LFSR checker enabled by FIFO_RD_STREAM_CHK_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int               DSIZE    = 8,
  parameter int               CNT_W    = 16,
  parameter logic [DSIZE-1:0] CHK_POLY = CHK_POLY_DEF,
  parameter logic [DSIZE-1:0] CHK_SEED = CHK_SEED_DEF
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [DSIZE-1:0] rd_data,
  input  logic             rd_empty,
  output logic             rd_inc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic             chk_err,
  output logic [7:0]       err_cnt
);

  occ_t             occ, occ_n;
  logic [DSIZE-1:0] h, h_n;
  logic [DSIZE-1:0] t, t_n;
  logic             pop;
  logic             xfer;

  // pop only from registered occupancy, never from out_ready
  assign rd_inc    = !rd_rst && !rd_empty && (occ != OCC2);
  assign pop       = rd_inc;
  assign out_valid = (occ != OCC0);
  assign out_data  = h;
  assign xfer      = out_valid && out_ready;

  // occupancy next-state and head/tail loads
  always_comb begin
    occ_n = occ;
    h_n   = h;
    t_n   = t;
    unique case (occ)
      OCC0: begin
        if (pop) begin
          h_n   = rd_data;
          occ_n = OCC1;
        end
      end
      OCC1: begin
        if (pop && xfer) begin
          h_n = rd_data;
        end else if (pop) begin
          t_n   = rd_data;
          occ_n = OCC2;
        end else if (xfer) begin
          occ_n = OCC0;
        end
      end
      OCC2: begin
        if (xfer) begin
          h_n   = t;
          occ_n = OCC1;
        end
      end
      default: occ_n = OCC0;
    endcase
  end

  // occupancy and skid registers
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ <= OCC0;
      h   <= '0;
      t   <= '0;
    end else begin
      occ <= occ_n;
      h   <= h_n;
      t   <= t_n;
    end
  end

  // delivered-word counter, wraps naturally
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)    word_cnt <= '0;
    else if (xfer) word_cnt <= word_cnt + 1'b1;
  end

`ifdef FIFO_RD_STREAM_CHK_EN
  logic [DSIZE-1:0] exp_w;

  fifo_lfsr #(
    .WIDTH (DSIZE),
    .POLY  (CHK_POLY),
    .SEED  (CHK_SEED)
  ) u_lfsr (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .step   (xfer),
    .value  (exp_w)
  );

  // compare each delivered word against the expected sequence
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      chk_err <= 1'b0;
      err_cnt <= 8'h00;
    end else if (xfer && (out_data != exp_w)) begin
      chk_err <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
  end
`else
  logic unused_chk;

  assign unused_chk = ^{CHK_POLY, CHK_SEED};
  assign chk_err    = 1'b0;
  assign err_cnt    = 8'h00;
`endif

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the async FIFO, clocked on the FIFO read clock. Pops words through the FIFO read port (`rd_data`/`rd_empty`/`rd_inc`) and re-presents them downstream as a registered valid/ready stream. A 2-entry skid buffer decouples downstream backpressure from `rd_inc`, and a delivered-word counter is maintained. An optional LFSR data checker verifies the word sequence produced by the matching write-side generator.

## Interface
- `DSIZE`, 8, data width; must match the FIFO `DSIZE`.
- `CNT_W`, 16, width of the delivered-word counter.
- `CHK_POLY`, 8'hB8, Galois LFSR tap mask, DSIZE bits. Used only with the checker.
- `CHK_SEED`, 8'hA5, LFSR reset value, nonzero. Used only with the checker.

Ports:
- `rd_clk`  in  1  read-domain clock; all logic uses the rising edge.
- `rd_rst`  in  1  asynchronous, active-high reset.
- `rd_data`  in  DSIZE  FIFO head word; valid while `rd_empty`=0 (first-word fall-through).
- `rd_empty`  in  1  FIFO empty flag.
- `rd_inc`  out  1  pop strobe to the FIFO; the pop takes effect at the rising edge.
- `out_data`  out  DSIZE  downstream data.
- `out_valid`  out  1  downstream valid.
- `out_ready`  in  1  downstream ready.
- `word_cnt`  out  CNT_W  count of completed downstream transfers.
- `chk_err`  out  1  sticky mismatch flag (checker only).
- `err_cnt`  out  8  saturating mismatch count (checker only).

## Operation
- Buffer occupancy FSM, encoded as `OCC0`, `OCC1`, `OCC2`. Head register `h`, tail register `t`.
- `rd_inc = !rd_empty && (occ != OCC2)`. This is purely registered state plus `rd_empty`. There is no combinational path from `out_ready`.
- Transfer condition: `xfer = out_valid && out_ready`.
- `OCC0`: on pop, `h <= rd_data` and the FSM moves to `OCC1`.
- `OCC1`:
  - pop & xfer: `h <= rd_data`, stay in `OCC1`.
  - pop only: `t <= rd_data`, go to `OCC2`.
  - xfer only: go to `OCC0`.
- `OCC2`: no pop is possible. On xfer, `h <= t` and the FSM moves to `OCC1`.
- `out_valid = (occ != OCC0)` and `out_data = h`. Both are driven directly from registers.
- Word order is strictly preserved. No word is dropped or duplicated.
- `word_cnt` increments by 1 on each xfer and wraps modulo 2^CNT_W.
- Reset asserted mid-operation clears the buffer; buffered words are discarded. The FIFO is reset by the same system reset.

## Timing
- Reset values:
  - `occ` = `OCC0`
  - `out_valid` = 0
  - `out_data` = 0
  - `word_cnt` = 0
  - `chk_err` = 0
  - `err_cnt` = 0
  - LFSR = `CHK_SEED`
- During reset, `rd_inc` = 0 regardless of `rd_empty`.
- Latency: a word popped at edge N appears on `out_data` with `out_valid`=1 after edge N (one cycle).
- With `out_ready` held high and the FIFO non-empty, throughput is 1 word/cycle, sustained in `OCC1`.
- With `out_ready` held low, at most 2 pops occur; `rd_inc` stays low afterwards.
- While `out_valid`=1 and no xfer occurs, `out_data` must not change.

## Configuration
- Macro: `FIFO_RD_STREAM_CHK_EN`.
- Defined:
  - An internal `fifo_lfsr` holds the expected word and advances one step per xfer.
  - On each xfer, `out_data` is compared with the LFSR value.
  - On mismatch, `chk_err` is set (sticky until reset) and `err_cnt` increments, saturating at 8'hFF. Both update at the xfer edge.
- Undefined:
  - No LFSR is instantiated.
  - `chk_err` and `err_cnt` are tied to 0.
  - The ports remain present.

## Structure
- Package `fifo_pkg` holds:
  - the `occ_t` enum (`OCC0`, `OCC1`, `OCC2`);
  - the default `CHK_POLY`/`CHK_SEED` constants, shared with the write-side generator.
- Sub-module `fifo_lfsr`:
  - parameters `WIDTH`, `POLY`, `SEED`;
  - ports `rd_clk`, `rd_rst`, `step`, `value`.
  - It is the same module the write-side generator instantiates, so both ends produce an identical sequence.

## Test plan
- **Reset:** hold `rd_rst`=1 with `rd_empty`=0 → `rd_inc`=0, `out_valid`=0, `word_cnt`=0, `err_cnt`=0.
- **Single word:** `rd_empty`=0 with `rd_data`=8'h3C for one cycle, `out_ready`=1 → `rd_inc`=1 that cycle. Next cycle `out_valid`=1 and `out_data`=8'h3C. After the following edge, `word_cnt`=1 and `out_valid`=0.
- **Backpressure:** FIFO holds 8'h01..8'h05 and `out_ready`=0 → exactly 2 `rd_inc` pulses, then `out_data` holds 8'h01 steady. Raise `out_ready` → outputs 8'h01..8'h05 in order, `word_cnt`=5.
- **Streaming:** `out_ready`=1 and FIFO non-empty for 8 cycles → 8 consecutive cycles with `out_valid`=1, no bubbles, `word_cnt`=8.
- **Counter wrap:** preload the bench so that `word_cnt`=16'hFFFF, then perform one xfer → `word_cnt`=16'h0000.
- **Checker (`FIFO_RD_STREAM_CHK_EN`):** feed the LFSR sequence from `CHK_SEED`=8'hA5 with the 3rd word XOR 8'h01 → `chk_err` rises after the 3rd xfer. Result: `err_cnt`=1, and the remaining words pass with no further increments.
